// File: rtl/shapool_pkg.sv
// Shared definitions for the share-check path: difficulty code width,
// saturation level for the reported difficulty, and the meter FSM states.
// Pure declarations; no logic, no latency, no flow control.
package shapool_pkg;

  // Difficulty code N means the top N hash bits must be zero.
  localparam int DIFF_CODE_W    = 4;
  localparam int DIFF_MAX_LEVEL = 15;

  // Hash difficulty meter states.
  //   METER_ZERO   : every hash bit accepted so far is zero
  //   METER_SKIP   : a one has been seen, remaining words are drained
  //   METER_RESULT : result held on the output until accepted
  typedef enum logic [1:0] {
    METER_ZERO   = 2'd0,
    METER_SKIP   = 2'd1,
    METER_RESULT = 2'd2
  } meter_state_e;

  // Saturate a leading-zero count to the largest reportable difficulty level.
  function automatic logic [DIFF_CODE_W-1:0] sat_level(input logic [31:0] lz);
    if (lz > 32'(DIFF_MAX_LEVEL)) begin
      sat_level = DIFF_CODE_W'(DIFF_MAX_LEVEL);
    end else begin
      sat_level = lz[DIFF_CODE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/word_lzc.sv
// Leading-zero count of one word (priority encoder from the MSB down).
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, the result follows the input directly.
module word_lzc #(
  parameter int WORD_WIDTH = 16
) (
  input  logic [WORD_WIDTH-1:0]         word,
  output logic [$clog2(WORD_WIDTH+1)-1:0] lzc
);

  localparam int CNT_W = $clog2(WORD_WIDTH+1);

  logic found;

  // Scan from the MSB; the first one found fixes the count. An all-zero
  // word keeps the default of WORD_WIDTH.
  always_comb begin
    lzc   = CNT_W'(WORD_WIDTH);
    found = 1'b0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (!found && word[i]) begin
        lzc   = CNT_W'(WORD_WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_difficulty_meter.sv
// Counts leading zeros of a streamed hash (MS word first) and checks it against a difficulty code.
// Latency: out_valid rises the cycle after the last word is accepted; HASH_WORDS+1 cycles per hash.
// Backpressure: in_ready drops while a result is pending and returns the cycle after out_ready handshake.
module hash_difficulty_meter
  import shapool_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int HASH_WORDS = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [WORD_WIDTH-1:0]                       in_word,
  input  logic [DIFF_CODE_W-1:0]                      target_code,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [$clog2(HASH_WORDS*WORD_WIDTH+1)-1:0]  out_lz,
  output logic [DIFF_CODE_W-1:0]                      out_level,
  output logic                                        out_match
);

  localparam int LZW   = $clog2(HASH_WORDS*WORD_WIDTH+1);
  localparam int WLZ_W = $clog2(WORD_WIDTH+1);
  localparam int IDX_W = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HASH_WORDS - 1);

  meter_state_e           state_q,     state_d;
  logic [IDX_W-1:0]       idx_q,       idx_d;
  logic [LZW-1:0]         lz_acc_q,    lz_acc_d;
  logic [DIFF_CODE_W-1:0] tgt_q,       tgt_d;
  logic [LZW-1:0]         out_lz_q,    out_lz_d;
  logic [DIFF_CODE_W-1:0] out_level_q, out_level_d;
  logic                   out_match_q, out_match_d;

  logic [WLZ_W-1:0]       word_lzc_w;
  logic                   accept;
  logic [LZW-1:0]         lz_next;
  logic [DIFF_CODE_W-1:0] tgt_eff;

  word_lzc #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_word_lzc (
    .word (in_word),
    .lzc  (word_lzc_w)
  );

  // Handshake decode from the state register only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_q != METER_RESULT);
  assign out_valid = (state_q == METER_RESULT);
  assign accept    = in_valid && in_ready;

  assign out_lz    = out_lz_q;
  assign out_level = out_level_q;
  assign out_match = out_match_q;

  // Count contributed by the word on the input: only words seen while all
  // earlier bits were zero add to the total. Word 0 compares against the
  // live target_code since the latch only loads on that same edge.
  always_comb begin
    lz_next = lz_acc_q;
    if (state_q == METER_ZERO) begin
      lz_next = lz_acc_q + LZW'(word_lzc_w);
    end
    tgt_eff = (idx_q == '0) ? target_code : tgt_q;
  end

  // Next-state, counter, accumulator, target latch and result capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lz_acc_d    = lz_acc_q;
    tgt_d       = tgt_q;
    out_lz_d    = out_lz_q;
    out_level_d = out_level_q;
    out_match_d = out_match_q;

    unique case (state_q)
      METER_ZERO, METER_SKIP: begin
        if (accept) begin
          if (idx_q == '0) begin
            tgt_d = target_code;
          end
          lz_acc_d = lz_next;
          if (idx_q == LAST_IDX) begin
            // Last word wins over the ZERO->SKIP move.
            state_d     = METER_RESULT;
            out_lz_d    = lz_next;
            out_level_d = sat_level(32'(lz_next));
            out_match_d = (lz_next >= LZW'(tgt_eff));
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if ((state_q == METER_ZERO) && (word_lzc_w < WLZ_W'(WORD_WIDTH))) begin
              state_d = METER_SKIP;
            end
          end
        end
      end
      METER_RESULT: begin
        if (out_ready) begin
          state_d  = METER_ZERO;
          idx_d    = '0;
          lz_acc_d = '0;
        end
      end
      default: begin
        state_d  = METER_ZERO;
        idx_d    = '0;
        lz_acc_d = '0;
      end
    endcase
  end

  // State and result registers; reset discards any partial hash or pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= METER_ZERO;
      idx_q       <= '0;
      lz_acc_q    <= '0;
      tgt_q       <= '0;
      out_lz_q    <= '0;
      out_level_q <= '0;
      out_match_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lz_acc_q    <= lz_acc_d;
      tgt_q       <= tgt_d;
      out_lz_q    <= out_lz_d;
      out_level_q <= out_level_d;
      out_match_q <= out_match_d;
    end
  end

endmodule

// File: doc/hash_difficulty_meter.md
# hash_difficulty_meter

Streaming consumer of candidate hashes that measures how many leading zero bits a hash has and decides whether it meets a 4-bit difficulty code. The code uses the same meaning as the difficulty-mask lookup: code N means the top N bits must be zero. The block sits after the SHA core in the share path. It accepts the hash as WORD_WIDTH-bit words, most significant word first, and emits one result per hash over a valid/ready handshake.

## Interface
- `WORD_WIDTH`, 16: bits per input word.
- `HASH_WORDS`, 16: words per hash (256-bit hash).
- `clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `in_word` is valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_word` in WORD_WIDTH: hash word, MS word first, MSB is the hash MSB.
- `target_code` in 4: required difficulty code, 0..15.
- `out_valid` out 1: result valid, held until accepted.
- `out_ready` in 1: downstream accepts the result.
- `out_lz` out LZW: total leading zeros, 0..HASH_WORDS*WORD_WIDTH. LZW = $clog2(HASH_WORDS*WORD_WIDTH+1), which is 9 at the defaults.
- `out_level` out 4: `out_lz` saturated at 15.
- `out_match` out 1: `out_lz >= target_code`.

## Operation
- A word is accepted when `in_valid && in_ready`. Words may have bubbles. Word order defines significance.
- States:
  - ZERO: every bit so far is zero.
  - SKIP: a one has been seen; remaining words are drained and ignored.
  - RESULT: holding the result.
- Word LZC: a combinational count of leading zeros in `in_word`, range 0..WORD_WIDTH.
- ZERO, on accept: `lz_acc += word_lzc`. If `word_lzc < WORD_WIDTH`, go to SKIP; otherwise stay in ZERO.
- SKIP, on accept: `lz_acc` is unchanged.
- Word index counts accepted words, 0..HASH_WORDS-1. Accepting the word at index HASH_WORDS-1 moves to RESULT from either ZERO or SKIP. This takes priority over the ZERO→SKIP transition.
- `target_code` is latched on acceptance of word 0. Changes during the rest of the hash are ignored.
- RESULT:
  - `out_valid`=1; `in_ready`=0.
  - `out_lz`, `out_level` and `out_match` are stable.
  - On `out_valid && out_ready`, clear `lz_acc` and the word index and go to ZERO.
- `in_ready` = (state != RESULT). The block never consumes a word of the next hash while a result is pending.
- `out_match` is identical to "word 0 AND difficulty mask(target_code) == 0". The code spans 0..15, so the top 15 bits at most are masked. Target 0 always matches.
- All-zero hash: `out_lz` = HASH_WORDS*WORD_WIDTH, with no overflow because LZW holds that value.
- Reset at any time, including mid-hash or with a result pending: state ZERO, index 0, `lz_acc` 0, latched target 0. Partial words are discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_lz`=0, `out_level`=0, `out_match`=0.
- Latency: `out_valid` rises the cycle after the last word is accepted.
- Back-to-back throughput: HASH_WORDS accept cycles plus 1 result cycle per hash when `out_ready` is held high.
- The cycle the result is accepted, `in_ready` is still 0. Word 0 of the next hash can be accepted the following cycle.
- Outputs are registered. `in_ready` is decoded from the state register only, with no combinational path from `out_ready`.
- `out_level` and `out_match` are computed from `lz_acc` when entering RESULT and registered with `out_lz`.

## Structure
- Shared package `shapool_pkg`:
  - `DIFF_CODE_W`=4.
  - `DIFF_MAX_LEVEL`=15.
  - Meter state enum {ZERO, SKIP, RESULT}.
- Sub-module `word_lzc`: parameterised by WORD_WIDTH; purely combinational priority encoder; output width $clog2(WORD_WIDTH+1). Reusable by other share-check logic.
- Top: FSM, word index counter, `lz_acc`, target latch, output registers.

## Test plan
- All 16 words 0x0000, target 15 → `out_lz`=256, `out_level`=15, `out_match`=1, `out_valid` exactly 1 cycle after word 15.
- Word 0 = 0x0100, rest 0xFFFF → `out_lz`=7, `out_level`=7. With target 7, `out_match`=1. Repeat with target 8 → `out_match`=0. The result appears only after all 16 words.
- Word 0 = 0x0000, word 1 = 0x8000 → `out_lz`=16, `out_level`=15. Word 0 = 0x0001 → `out_lz`=15, `out_level`=15, `out_match`=1 for target 15.
- Random `in_valid` bubbles plus `out_ready` held low 5 cycles → identical results to the bubble-free run. `in_ready`=0 and outputs frozen while pending. The next hash's word 0 is accepted the cycle after the handshake.
- `target_code` changed 15→0 after word 0 of a hash with `out_lz`=3 (started with 15) → `out_match`=0, proving the latched value is used.
- `reset` pulsed after 5 words, then a fresh all-zero hash → no spurious `out_valid`; fresh result `out_lz`=256.
